// File: rtl/rising_edge_reader.sv
// rtl/rising_edge_reader.sv - FIFO capturing a falling-edge-launched writer on the rising edge; READER_COUNT_EN adds Count
module rising_edge_reader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  output logic             Din_ready,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_valid,
  input  logic             Dout_ready
`ifdef READER_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] Count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             full;
  logic             empty;
  logic             do_write;
  logic             do_read;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign Din_ready  = !full && !RST;
  assign Dout_valid = !empty;
  assign do_write   = Din_valid && Din_ready;
  assign do_read    = Dout_valid && Dout_ready && !RST;
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_write};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_read};

  // Next head word: the word being written when it lands in the head slot, else the stored entry; hold when empty.
  always_comb begin
    head_nxt = Dout;
    if (rd_ptr_nxt != wr_ptr_nxt) begin
      if (do_write && (rd_ptr_nxt[AW-1:0] == wr_ptr[AW-1:0])) begin
        head_nxt = Din;
      end else begin
        head_nxt = mem[rd_ptr_nxt[AW-1:0]];
      end
    end
  end

  // Storage array is written only on accepted words and never cleared.
  always_ff @(posedge CLK) begin
    if (do_write) begin
      mem[wr_ptr[AW-1:0]] <= Din;
    end
  end

  // Pointers and registered head word; reset drops every stored word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      Dout   <= head_nxt;
    end
  end

`ifdef READER_COUNT_EN
  // Occupancy counter: up on write-only, down on read-only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Count <= '0;
    end else if (do_write && !do_read) begin
      Count <= Count + {{AW{1'b0}}, 1'b1};
    end else if (do_read && !do_write) begin
      Count <= Count - {{AW{1'b0}}, 1'b1};
    end
  end
`endif

endmodule
